// File: rtl/face_uart_pkg.sv
// Shared types and default geometry for the face-detection host link.
package face_uart_pkg;
  localparam int IMG_W        = 40;
  localparam int IMG_H        = 30;
  localparam int CLKS_PER_BIT = 54;

  // Field order matches the wire order: found goes out first.
  typedef struct packed {
    logic [7:0] found;
    logic [7:0] c0;
    logic [7:0] r0;
    logic [7:0] c1;
    logic [7:0] r1;
  } face_rec_t;

  typedef enum logic { LOAD, BUSY } fill_state_t;
  typedef enum logic [1:0] { IDLE, START, DATA, STOP } tx_state_t;
  typedef enum logic [1:0] { RX_IDLE, RX_START, RX_DATA, RX_STOP } rx_state_t;
endpackage

// File: rtl/face_uart_bridge_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampler, one-cycle valid per good byte.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 54
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  import face_uart_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1, rx_s2, rx_prev;
  rx_state_t     state, state_next;
  logic [TW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          valid_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + TW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    valid_next = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s2) state_next = RX_START;
      end
      RX_START: if (cnt == HALF_LAST) begin
        // A start bit that is high again at mid-bit was a glitch.
        cnt_next   = '0;
        bit_next   = '0;
        state_next = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_LAST) begin
        cnt_next   = '0;
        shift_next = {rx_s2, shift[7:1]};
        bit_next   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_next = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_LAST) begin
        cnt_next   = '0;
        valid_next = rx_s2;
        state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      valid   <= valid_next;
      if (valid_next) data <= shift;
    end
  end
endmodule

// File: rtl/face_uart_bridge.sv
// Host link: fills the frame buffer from UART RX, then streams detection and
// end-of-frame records back over UART TX as 5-byte messages.
module face_uart_bridge #(
  parameter int IMG_W        = face_uart_pkg::IMG_W,
  parameter int IMG_H        = face_uart_pkg::IMG_H,
  parameter int CLKS_PER_BIT = face_uart_pkg::CLKS_PER_BIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     uart_rx,
  input  logic                     uart_cts,
  output logic                     uart_tx,
  output logic                     uart_rts,
  output logic [IMG_H*IMG_W*8-1:0] laptop_img,
  output logic                     laptop_img_rdy,
  input  logic                     face_valid,
  output logic                     face_ready,
  input  logic [7:0]               face_r0,
  input  logic [7:0]               face_c0,
  input  logic [7:0]               face_r1,
  input  logic [7:0]               face_c1,
  input  logic                     vj_pipeline_done
);
  import face_uart_pkg::*;

  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int OW = $clog2(IMG_H * IMG_W * 8);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock (clock),
    .reset (reset),
    .rx    (uart_rx),
    .data  (rx_data),
    .valid (rx_valid)
  );

  fill_state_t   fill_state, fill_next;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          pix_we, last_pix;
  logic [OW-1:0] pix_off;

  assign pix_we   = rx_valid && (fill_state == LOAD);
  assign last_pix = pix_we && (row == ROW_LAST) && (col == COL_LAST);
  assign pix_off  = OW'((int'(row) * IMG_W + int'(col)) * 8);
  assign uart_rts = (fill_state == LOAD);

  always_comb begin
    fill_next = fill_state;
    if (last_pix) fill_next = BUSY;
    if (vj_pipeline_done) fill_next = LOAD;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fill_state     <= LOAD;
      row            <= '0;
      col            <= '0;
      laptop_img     <= '0;
      laptop_img_rdy <= 1'b0;
    end else begin
      fill_state     <= fill_next;
      laptop_img_rdy <= last_pix;
      if (pix_we) begin
        laptop_img[pix_off +: 8] <= rx_data;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Handshake (valid/ready): a record transfers on a cycle where face_valid
  // and face_ready are both high; face_valid has no other effect.
  face_rec_t hold;
  logic      hold_full, end_pending, hs, load_end, free_hold;

  assign face_ready = !hold_full && !end_pending;
  assign hs         = face_valid && face_ready;
  assign load_end   = end_pending && !hold_full;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      end_pending <= 1'b0;
    end else begin
      end_pending <= (end_pending && !load_end) || vj_pipeline_done;
      if (hs) begin
        hold      <= '{found: 8'h01, c0: face_c0, r0: face_r0, c1: face_c1, r1: face_r1};
        hold_full <= 1'b1;
      end else if (load_end) begin
        hold      <= '0;
        hold_full <= 1'b1;
      end else if (free_hold) begin
        hold_full <= 1'b0;
      end
    end
  end

  tx_state_t     tx_state, tx_next;
  logic [TW-1:0] tx_cnt, cnt_next;
  logic [2:0]    tx_bit, bit_next, tx_byte, byte_next;
  logic [7:0]    cur_byte;
  logic          cnt_done, line_next;

  assign cnt_done = (tx_cnt == BIT_LAST);

  always_comb begin
    case (tx_byte)
      3'd0:    cur_byte = hold.found;
      3'd1:    cur_byte = hold.c0;
      3'd2:    cur_byte = hold.r0;
      3'd3:    cur_byte = hold.c1;
      default: cur_byte = hold.r1;
    endcase
  end

  // The record being loaded this cycle counts as available so the start bit
  // lands in the cycle right after the handshake.
  always_comb begin
    tx_next   = tx_state;
    cnt_next  = tx_cnt + TW'(1);
    bit_next  = tx_bit;
    byte_next = tx_byte;
    free_hold = 1'b0;
    line_next = 1'b1;
    case (tx_state)
      IDLE: begin
        cnt_next = '0;
        if ((hold_full || hs || load_end) && uart_cts) tx_next = START;
      end
      START: if (cnt_done) begin
        cnt_next = '0;
        bit_next = '0;
        tx_next  = DATA;
      end
      DATA: if (cnt_done) begin
        cnt_next = '0;
        bit_next = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_next = STOP;
      end
      STOP: if (cnt_done) begin
        cnt_next = '0;
        if (tx_byte == 3'd4) begin
          free_hold = 1'b1;
          byte_next = '0;
          tx_next   = IDLE;
        end else begin
          byte_next = tx_byte + 3'd1;
          tx_next   = uart_cts ? START : IDLE;
        end
      end
      default: tx_next = IDLE;
    endcase
    case (tx_next)
      START:   line_next = 1'b0;
      DATA:    line_next = cur_byte[bit_next];
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= cnt_next;
      tx_bit   <= bit_next;
      tx_byte  <= byte_next;
      uart_tx  <= line_next;
    end
  end
endmodule

// File: tb/tb_face_uart_bridge.sv
// Bench for face_uart_bridge: frame load over UART RX, record streaming over TX.
module tb_face_uart_bridge;
  localparam int IMG_W = 13;
  localparam int IMG_H = 8;
  localparam int CPB   = 20;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IMGB  = NPIX * 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            uart_rx = 1'b1;
  logic            uart_cts = 1'b1;
  logic            uart_tx, uart_rts, laptop_img_rdy, face_ready;
  logic [IMGB-1:0] laptop_img;
  logic            face_valid = 1'b0;
  logic [7:0]      face_r0 = '0, face_c0 = '0, face_r1 = '0, face_c1 = '0;
  logic            vj_pipeline_done = 1'b0;

  face_uart_bridge #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CLKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx          (uart_rx),
    .uart_cts         (uart_cts),
    .uart_tx          (uart_tx),
    .uart_rts         (uart_rts),
    .laptop_img       (laptop_img),
    .laptop_img_rdy   (laptop_img_rdy),
    .face_valid       (face_valid),
    .face_ready       (face_ready),
    .face_r0          (face_r0),
    .face_c0          (face_c0),
    .face_r1          (face_r1),
    .face_c1          (face_c1),
    .vj_pipeline_done (vj_pipeline_done)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  int         rdy_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  r0, c0, r1, c1;
    logic [39:0] msg;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [IMGB-1:0] act, input logic [IMGB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [39:0] m);
    for (int b = 0; b < 5; b++) exp_q.push_back(m[39-8*b -: 8]);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n;
    n = 0;
    while (!face_ready && n < limit) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, 64'(face_ready), 64'(1));
  endtask

  // Hands one detection over, then times the start bit and the whole record.
  task automatic send_face(input logic [7:0] r0, c0, r1, c1, output int cycles, output int low_len);
    logic seen_high;
    wait_ready("ready_before_face", 200 * CPB);
    face_valid = 1'b1;
    face_r0 = r0; face_c0 = c0; face_r1 = r1; face_c1 = c1;
    @(posedge clock); #1;
    face_valid = 1'b0;
    check("ready_fall", 64'(face_ready), 64'(0));
    cycles = 0; low_len = 0; seen_high = 1'b0;
    while (!face_ready && cycles < 100 * CPB) begin
      if (!seen_high && uart_tx == 1'b0) low_len++;
      else seen_high = 1'b1;
      @(posedge clock); #1;
      cycles++;
    end
  endtask

  always @(negedge clock) if (laptop_img_rdy === 1'b1) rdy_cnt++;

  // Decodes every byte on uart_tx and checks it against the scoreboard.
  always begin : tx_monitor
    logic [7:0] got;
    logic [7:0] want;
    @(negedge clock);
    if (reset === 1'b1 && uart_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        got[i] = uart_tx;
      end
      repeat (CPB) @(negedge clock);
      check("tx_stop", 64'(uart_tx), 64'(1));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_byte: got %02h expected none", got);
      end else begin
        want = exp_q.pop_front();
        check("tx_byte", 64'(got), 64'(want));
      end
    end
  end

  initial begin
    logic [IMGB-1:0] exp_img;
    int cycles, low_len, n, lows;

    vecs[0] = '{r0: 8'd3,   c0: 8'd5,   r1: 8'd20,  c1: 8'd22,  msg: 40'h01_05_03_16_14};
    vecs[1] = '{r0: 8'h00,  c0: 8'h00,  r1: 8'h00,  c1: 8'h00,  msg: 40'h01_00_00_00_00};
    vecs[2] = '{r0: 8'hff,  c0: 8'hff,  r1: 8'hff,  c1: 8'hff,  msg: 40'h01_ff_ff_ff_ff};
    vecs[3] = '{r0: 8'h12,  c0: 8'h34,  r1: 8'h56,  c1: 8'h78,  msg: 40'h01_34_12_78_56};
    vecs[4] = '{r0: 8'h0a,  c0: 8'hc8,  r1: 8'h07,  c1: 8'h81,  msg: 40'h01_c8_0a_81_07};

    // Reset values
    repeat (3) @(posedge clock); #1;
    check("rst_tx", 64'(uart_tx), 64'(1));
    check("rst_rts", 64'(uart_rts), 64'(1));
    check("rst_rdy", 64'(laptop_img_rdy), 64'(0));
    check("rst_ready", 64'(face_ready), 64'(1));
    check_img("rst_img", laptop_img, '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 100 good bytes, then a bad-stop byte and a glitch that must not land
    exp_img = '0;
    for (int k = 0; k < 100; k++) begin
      uart_send(8'(k), 1'b1);
      exp_img[k*8 +: 8] = 8'(k);
    end
    uart_send(8'hEE, 1'b0);
    repeat (2 * CPB) @(negedge clock);
    uart_rx = 1'b0;
    @(negedge clock);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check_img("bad_frames_dropped", laptop_img, exp_img);
    uart_send(8'hA5, 1'b1);
    repeat (4) @(negedge clock);
    exp_img[100*8 +: 8] = 8'hA5;
    check_img("ptr_after_bad", laptop_img, exp_img);
    check("no_rdy_partial", 64'(rdy_cnt), 64'(0));

    // Reset in the middle of a byte (line high during data bits of 0xFF)
    fork
      uart_send(8'hFF, 1'b1);
      begin
        repeat (3 * CPB) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("midrst_tx", 64'(uart_tx), 64'(1));
        check("midrst_rts", 64'(uart_rts), 64'(1));
        check("midrst_ready", 64'(face_ready), 64'(1));
        check_img("midrst_img", laptop_img, '0);
        @(negedge clock);
        reset = 1'b1;
      end
    join
    repeat (2 * CPB) @(negedge clock);
    check_img("midrst_no_stray", laptop_img, '0);

    // Full frame
    exp_img = '0;
    for (int k = 0; k < NPIX; k++) begin
      uart_send(8'(k), 1'b1);
      exp_img[k*8 +: 8] = 8'(k);
    end
    repeat (4) @(negedge clock);
    check_img("frame_img", laptop_img, exp_img);
    check("frame_rdy_pulses", 64'(rdy_cnt), 64'(1));
    check("frame_rts_busy", 64'(uart_rts), 64'(0));

    // Bytes arriving while BUSY are dropped
    uart_send(8'h5A, 1'b1);
    repeat (4) @(negedge clock);
    check_img("busy_img_held", laptop_img, exp_img);
    check("busy_no_rdy", 64'(rdy_cnt), 64'(1));

    // Table of detection records, cts held high
    for (int v = 0; v < 5; v++) begin
      push_msg(vecs[v].msg);
      send_face(vecs[v].r0, vecs[v].c0, vecs[v].r1, vecs[v].c1, cycles, low_len);
      check("rec_cycles", 64'(cycles), 64'(50 * CPB));
      check("start_bit_len", 64'(low_len), 64'(CPB));
    end

    // Flow control: cts drops during byte 2
    push_msg(40'h01_02_01_04_03);
    wait_ready("ready_before_flow", 200 * CPB);
    face_valid = 1'b1;
    face_r0 = 8'h01; face_c0 = 8'h02; face_r1 = 8'h03; face_c1 = 8'h04;
    @(posedge clock); #1;
    face_valid = 1'b0;
    n = 0;
    while (n < 23 * CPB) begin
      @(posedge clock); #1;
      n++;
    end
    uart_cts = 1'b0;
    while (n < 30 * CPB) begin
      @(posedge clock); #1;
      n++;
    end
    lows = 0;
    repeat (6 * CPB) begin
      @(posedge clock); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check("cts_hold_idle", 64'(lows), 64'(0));
    uart_cts = 1'b1;
    @(posedge clock); #1;
    check("cts_resume_start", 64'(uart_tx), 64'(0));
    wait_ready("ready_after_flow", 100 * CPB);

    // Detection and end-of-frame in the same cycle
    push_msg(40'h01_08_09_06_07);
    push_msg(40'h00_00_00_00_00);
    wait_ready("ready_before_end", 200 * CPB);
    face_valid = 1'b1;
    vj_pipeline_done = 1'b1;
    face_r0 = 8'h09; face_c0 = 8'h08; face_r1 = 8'h07; face_c1 = 8'h06;
    @(posedge clock); #1;
    face_valid = 1'b0;
    vj_pipeline_done = 1'b0;
    check("end_ready_fall", 64'(face_ready), 64'(0));
    check("end_rts_load", 64'(uart_rts), 64'(1));
    wait_ready("ready_after_end", 150 * CPB);
    repeat (CPB) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/face_uart_bridge.md
# face_uart_bridge

Host-link front end of the face-detection system. It receives a grayscale image byte-by-byte over an 8N1 UART and stores it in a frame buffer. When the frame is complete it hands the frame to the external Viola-Jones detector. It then serializes each detection result, and a final end-of-frame record, back to the host as 5-byte UART messages.

## Interface
Parameters:
- `IMG_W`, default 40: image width in pixels (`LAPTOP_WIDTH`).
- `IMG_H`, default 30: image height in pixels (`LAPTOP_HEIGHT`).
- `CLKS_PER_BIT`, default 54: clock cycles per UART bit.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-low; 0 = reset.
- `uart_rx`, in, 1: serial data from the host; idles high.
- `uart_cts`, in, 1: 1 = host may accept TX data.
- `uart_tx`, out, 1: serial data to the host; idles high.
- `uart_rts`, out, 1: 1 = block accepts RX data.
- `laptop_img`, out, IMG_H·IMG_W·8: frame buffer; pixel [r][c] sits at bits ((r·IMG_W+c)·8) +: 8.
- `laptop_img_rdy`, out, 1: one-cycle pulse when the frame is complete.
- `face_valid`, in, 1: a detection record is presented.
- `face_ready`, out, 1: a record is accepted when `face_valid` and `face_ready` are both high.
- `face_r0`, `face_c0`, `face_r1`, `face_c1`, in, 8 each: box from (r0,c0) to (r1,c1).
- `vj_pipeline_done`, in, 1: pulse; the detector has finished the current frame.

## Operation
- **RX.** 8N1 format, LSB first.
  - A falling edge on `uart_rx` while idle starts a frame.
  - The start bit is re-sampled at CLKS_PER_BIT/2; if it reads 1, the receiver returns to idle.
  - Each data bit is sampled mid-bit, CLKS_PER_BIT cycles apart.
  - If the stop bit samples 0, the byte is discarded.
  - `uart_rx` passes through a 2-flop synchronizer before use.
- **Frame fill.**
  - States: LOAD, BUSY.
  - In LOAD, each valid byte is written to buffer[row][col]. `col` increments; at IMG_W−1 it wraps to 0 and `row` increments.
  - After pixel [IMG_H−1][IMG_W−1] is written: pulse `laptop_img_rdy`, reset the pointer to (0,0), go to BUSY.
  - In BUSY, `uart_rts`=0 and received bytes are dropped; `laptop_img` is held stable.
  - `vj_pipeline_done` queues the end record and returns the state to LOAD.
- **Records.**
  - Byte order: found, c0, r0, c1, r1.
  - A detection record has found=1.
  - The end record is found=0 with all coordinates 0. It is sent after every detection accepted before it.
- **Record queue.**
  - Single holding register. `face_ready`=1 when the register is empty and no end record is pending.
  - If `vj_pipeline_done` and a face handshake occur in the same cycle, the face record is sent first and the end record is latched pending.
- **TX serializer.**
  - Sends the 5 bytes in order. Each byte is: start bit 0, 8 data bits LSB first, stop bit 1.
  - `uart_cts` is checked before each byte's start bit. While it is 0, the line stays high (idle) and the next byte waits.
  - The holding register is freed after the stop bit of byte 4.

## Timing
- Reset values: `uart_tx`=1, `uart_rts`=1, `laptop_img_rdy`=0, `face_ready`=1, buffer=0, pointer=(0,0), state LOAD.
- Reset has effect at the next clock edge. Reset mid-byte (RX or TX) aborts the byte immediately and drives `uart_tx` high.
- RX: the byte is written in the cycle after the stop bit's mid-sample.
- `laptop_img_rdy` rises in the cycle after the last pixel write. It is high for exactly one cycle.
- TX: the start bit begins in the cycle after the handshake, if `uart_cts`=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - A record takes 50·CLKS_PER_BIT cycles when `uart_cts` stays 1.
- `face_ready` falls in the cycle after the handshake.

## Structure
- Package `face_uart_pkg` holds:
  - constants IMG_W, IMG_H, CLKS_PER_BIT;
  - `face_rec_t` struct {found, c0, r0, c1, r1}, each logic [7:0];
  - state enum {LOAD, BUSY};
  - TX state enum {IDLE, START, DATA, STOP}.
- One sub-module, `uart_byte_rx`: synchronizer, sampler, and output `data[7:0]` plus a one-cycle `valid`.
- The TX serializer and frame-fill logic are in-line in `face_uart_bridge`.

## Test plan
- **Frame load:** send IMG_H·IMG_W bytes where byte k = k mod 256 → `laptop_img`[r][c] = (r·IMG_W+c) mod 256; one `laptop_img_rdy` pulse; `uart_rts`=0.
- **Detection:** present face_valid with r0=3, c0=5, r1=20, c1=22 → TX bytes 01, 05, 03, 16, 14 (hex) on the line, each bit exactly 54 cycles.
- **End record, simultaneous:** `vj_pipeline_done` in the same cycle as a face handshake → face record first, then 00 00 00 00 00; `uart_rts` returns to 1.
- **Flow control:** drop `uart_cts` during byte 2 → byte 2 completes, `uart_tx` stays high while waiting, byte 3 starts when `uart_cts` rises.
- **Bad frames:** send a byte with stop bit 0, and a 1-cycle glitch low on `uart_rx` → neither is written; the pointer is unchanged.
- **Reset mid-frame:** assert reset after 100 bytes → pointer (0,0), `uart_tx`=1, buffer cleared; a full new frame then loads correctly.
